audio_fx_engine: RTL
====================

# audio_fx_engine

Parametrised multi-channel effects engine that supersedes the fixed two-channel clip/echo path between the I2S decoder and encoder. It accepts one frame of CHANNELS signed samples per strobe and applies a saturating gain shift, then an optional echo from a per-channel circular delay line. Channels are processed time-multiplexed through one datapath, and the processed frame is handed back with a one-cycle valid pulse. It runs in the data-clock domain alongside the I2S blocks.

## Interface
- WIDTH, 32, sample width in bits, two's complement
- CHANNELS, 2, channels per frame, ≥1
- DEPTH, 128, delay-line length per channel in samples, power of two, ≥4
- GAIN_BITS, 2, width of the gain shift control

- clk  in  1  data clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  frame strobe; sampled only when the engine can accept
- in_data  in  CHANNELS*WIDTH  frame; channel c at [c*WIDTH +: WIDTH]
- gain  in  GAIN_BITS  left-shift amount, 0..2^GAIN_BITS-1
- echo_en  in  1  enables the echo term
- delay  in  $clog2(DEPTH)  echo delay in frames; 0 means no echo
- out_valid  out  1  one-cycle pulse when out_data holds a new frame
- out_data  out  CHANNELS*WIDTH  processed frame, same packing as in_data
- busy  out  1  high while a frame is in process
- overrun  out  1  sticky; a frame was dropped

## Operation
- FSM states: IDLE, GAIN, READ, MIX, DONE. Channel counter ch runs 0..CHANNELS-1.
- Frame acceptance:
  - in_valid in IDLE or DONE latches in_data and gain/echo_en/delay, sets ch=0 and moves to GAIN.
  - In any other state in_valid sets overrun and the frame is discarded.
- GAIN: x_g = in[ch] << gain, saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- READ:
  - Issues a synchronous read of bank ch at (wr_ptr - delay) mod DEPTH. Memory is CHANNELS*DEPTH words.
  - Echo term e = rd_data when echo_en=1, delay≠0 and delay≤fill; otherwise e = 0.
- MIX:
  - y = sat(x_g + (e >>> 1)), arithmetic shift, computed at WIDTH+1 bits, then saturated.
  - Stores y into out_data[ch] and writes the delay line at bank ch, address wr_ptr.
  - If ch<CHANNELS-1: ch++ and go to GAIN; else go to DONE.
- DONE:
  - out_valid=1.
  - wr_ptr = wr_ptr+1 mod DEPTH (wraps DEPTH-1→0).
  - fill = min(fill+1, DEPTH-1).
  - Next state is IDLE, or GAIN if a new frame is accepted in the same cycle.
- busy is high in GAIN, READ and MIX; low in IDLE and DONE.
- Gain and echo controls are latched per frame, so changes mid-frame take effect on the next frame.

## Timing
- Reset values: out_valid=0, out_data=0, busy=0, overrun=0, state=IDLE, ch=0, wr_ptr=0, fill=0. Delay-line contents are not reset; fill gates their use.
- Latency: a frame accepted at edge E0 gives out_valid high during the cycle after edge E0+3*CHANNELS+1. With defaults that is 7 edges.
- Throughput: one frame per 3*CHANNELS+1 cycles, with back-to-back acceptance in DONE.
- out_data is stable from the out_valid cycle until the MIX of the next frame's channel 0.
- Simultaneous in_valid and DONE: the frame is accepted and no overrun is raised.
- Reset asserted mid-frame: all outputs return to reset values immediately, the frame is lost, and the echo history is invalidated because fill=0.

## Configuration
- AUDIO_FX_FEEDBACK_EN defined: the delay line stores y (recirculating echo, decaying by half on each repeat).
- Undefined: the delay line stores x_g (single-tap echo, one repeat only).

## Test plan
All scenarios use WIDTH=16, CHANNELS=2, DEPTH=8.
- Passthrough: after reset, gain=0, echo_en=0, L=0x1234, R=-100 -> out_valid 7 edges after acceptance with L=0x1234, R=-100; busy low afterwards.
- Saturating gain: gain=2, L=4096, R=-12288 -> L=16384, R=-32768; then L=12288 -> 32767.
- Echo: echo_en=1, delay=3, gain=0, L frames 1000,0,0,0,0,0,0 -> outputs 1000,0,0,500,0,0,250 with the macro; 1000,0,0,500,0,0,0 without.
- Overrun: second in_valid two cycles after an acceptance -> overrun=1, first frame output unchanged, no extra out_valid; overrun held until reset.
- Reset mid-frame: reset during READ of ch1 -> out_valid/busy/overrun=0 at once; next frame with echo_en=1, delay=1 -> e=0 and output equals input.
- Wrap: delay=7, 20 ramp frames L=n*100 -> from frame 7 onward each output equals n*100 + ((n-7)*100 >>> 1) without the macro, including across wr_ptr 7→0.

Source files
------------

// File: rtl/audio_fx_engine.sv
// Multi-channel saturating gain plus delay-line echo, one channel at a time through a shared datapath.
// Define AUDIO_FX_FEEDBACK_EN to store the mixed output in the delay line (recirculating echo) instead of the gained input.
module audio_fx_engine #(
  parameter int WIDTH     = 32,
  parameter int CHANNELS  = 2,
  parameter int DEPTH     = 128,
  parameter int GAIN_BITS = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [GAIN_BITS-1:0]      gain,
  input  logic                      echo_en,
  input  logic [$clog2(DEPTH)-1:0]  delay,
  output logic                      out_valid,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic                      busy,
  output logic                      overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SW = WIDTH + (1 << GAIN_BITS);
  localparam logic [CW-1:0]    LAST_CH = CW'(CHANNELS - 1);
  localparam logic [AW-1:0]    FILL_MAX = AW'(DEPTH - 1);
  localparam logic [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, GAIN, READ, MIX, DONE} state_t;

  state_t                    state, state_nxt;
  logic [CW-1:0]             ch;
  logic [AW-1:0]             wr_ptr, fill, delay_q, rd_addr;
  logic [GAIN_BITS-1:0]      gain_q;
  logic                      echo_q;
  logic [CHANNELS*WIDTH-1:0] frame_q;
  logic [WIDTH-1:0]          x_in, xg, xg_q, rd_data, e, y, store;
  logic [SW-1:0]             wide;
  logic [WIDTH:0]            sum;
  logic                      accept;
  logic [WIDTH-1:0]          mem [CHANNELS*DEPTH];

  assign accept = in_valid && (state == IDLE || state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE: if (in_valid) state_nxt = GAIN;
      GAIN: begin state_nxt = READ; busy = 1'b1; end
      READ: begin state_nxt = MIX;  busy = 1'b1; end
      MIX: begin
        state_nxt = (ch == LAST_CH) ? DONE : GAIN;
        busy      = 1'b1;
      end
      DONE: state_nxt = in_valid ? GAIN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Gain: sign-extend wide enough that the largest shift cannot overflow, then clamp.
  always_comb begin
    x_in = frame_q[ch*WIDTH +: WIDTH];
    wide = {{(SW-WIDTH){x_in[WIDTH-1]}}, x_in} << gain_q;
    if (wide[SW-1:WIDTH-1] == {(SW-WIDTH+1){wide[SW-1]}}) xg = wide[WIDTH-1:0];
    else                                                   xg = wide[SW-1] ? S_MIN : S_MAX;
  end

  // History is only trusted once enough frames have been written since reset.
  always_comb begin
    rd_addr = wr_ptr - delay_q;
    e = (echo_q && delay_q != '0 && delay_q <= fill) ? rd_data : '0;
    sum = {xg_q[WIDTH-1], xg_q} + {e[WIDTH-1], e[WIDTH-1], e[WIDTH-1:1]};
    if (sum[WIDTH] != sum[WIDTH-1]) y = sum[WIDTH] ? S_MIN : S_MAX;
    else                            y = sum[WIDTH-1:0];
`ifdef AUDIO_FX_FEEDBACK_EN
    store = y;
`else
    store = xg_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (state == READ) rd_data <= mem[{ch, rd_addr}];
    if (state == MIX)  mem[{ch, wr_ptr}] <= store;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch        <= '0;
      wr_ptr    <= '0;
      fill      <= '0;
      delay_q   <= '0;
      gain_q    <= '0;
      echo_q    <= 1'b0;
      frame_q   <= '0;
      xg_q      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= (state == DONE);
      if (in_valid && !accept) overrun <= 1'b1;
      if (accept) begin
        frame_q <= in_data;
        gain_q  <= gain;
        echo_q  <= echo_en;
        delay_q <= delay;
        ch      <= '0;
      end
      if (state == GAIN) xg_q <= xg;
      if (state == MIX) begin
        out_data[ch*WIDTH +: WIDTH] <= y;
        if (ch != LAST_CH) ch <= ch + 1'b1;
      end
      if (state == DONE) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (fill != FILL_MAX) fill <= fill + 1'b1;
      end
    end
  end

endmodule
